// File: rtl/ofdm_pkg.sv
// ofdm_pkg -- shared OFDM definitions.
//   OFDM_N      : global samples-per-symbol used across the receive chain.
//   PWS_*       : defaults for payload_window_sel (sample width, symbol size,
//                 front/back guard lengths, symbol-count width).
//   payload_len : payload samples left in one symbol after guard removal.
package ofdm_pkg;

  localparam int OFDM_N = 512;

  localparam int PWS_DW = 14;
  localparam int PWS_N  = OFDM_N;
  localparam int PWS_GF = 16;
  localparam int PWS_GB = 16;
  localparam int PWS_SW = 4;

  function automatic int payload_len(input int n, input int gf, input int gb);
    return n - gf - gb;
  endfunction

endpackage

// File: rtl/payload_window_sel_sym_cnt.sv
// sym_sample_cnt -- sample index (k) and symbol index (s) tracking.
//   clk, rst_n   : clock, asynchronous active-low reset
//   frm_start    : restarts the frame (k = 0, s = 0, latches cfg_nsym)
//   di_vld       : input beat valid; advances k
//   cfg_nsym     : payload symbol count for the new frame
//   beat_k/s/nsym: k, s and symbol limit that apply to the beat presented this
//                  cycle (frm_start already folded in)
//   trunc        : a symbol is being cut short this cycle
module sym_sample_cnt
  import ofdm_pkg::*;
#(
  parameter int N  = PWS_N,
  parameter int SW = PWS_SW,
  parameter int KW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frm_start,
  input  logic          di_vld,
  input  logic [SW-1:0] cfg_nsym,
  output logic [KW-1:0] beat_k,
  output logic [SW-1:0] beat_s,
  output logic [SW-1:0] beat_nsym,
  output logic          trunc
);

  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  logic [KW-1:0] k, k_nxt;
  logic [SW-1:0] s, s_nxt;
  logic [SW-1:0] nsym_lat;

  // A beat coincident with frm_start already belongs to the new frame, so the
  // registered state is overridden before it is used anywhere.
  always_comb begin
    beat_k    = frm_start ? '0 : k;
    beat_s    = frm_start ? '0 : s;
    beat_nsym = frm_start ? cfg_nsym : nsym_lat;
  end

  // A gap is only legal on a symbol boundary; frm_start abandons the symbol
  // on purpose and is therefore never a truncation.
  assign trunc = !di_vld && !frm_start && (k != '0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    k_nxt = beat_k;
    s_nxt = beat_s;
    if (di_vld) begin
      if (beat_k == K_LAST) begin
        k_nxt = '0;
        // s stops at the symbol limit; suppressed symbols keep k counting.
        if (beat_s < beat_nsym) s_nxt = beat_s + 1'b1;
      end else begin
        k_nxt = beat_k + 1'b1;
      end
    end else begin
      // Idle at k == 0 keeps 0; a truncation restarts the same symbol.
      k_nxt = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      s        <= '0;
      nsym_lat <= '0;
    end else begin
      k <= k_nxt;
      s <= s_nxt;
      if (frm_start) nsym_lat <= cfg_nsym;
    end
  end

endmodule

// File: rtl/payload_window_sel.sv
// payload_window_sel -- strips front/back guard samples from each symbol and
// flags the payload portion of the first cfg_nsym symbols of a frame.
//   clk, rst_n      : clock, asynchronous active-low reset
//   frm_start       : one-cycle frame start; samples cfg_nsym
//   cfg_nsym        : payload symbols in the frame
//   di_re/di_im     : signed input sample, di_vld qualifies it
//   do_re/do_im     : input sample delayed by one cycle (always registered)
//   do_vld          : output sample is payload
//   do_sop/do_eop   : first/last payload sample of a symbol
//   do_sym          : symbol index of the current output
//   err_short       : one-cycle pulse when a symbol was cut short
module payload_window_sel
  import ofdm_pkg::*;
#(
  parameter int DW = PWS_DW,
  parameter int N  = PWS_N,
  parameter int GF = PWS_GF,
  parameter int GB = PWS_GB,
  parameter int SW = PWS_SW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frm_start,
  input  logic [SW-1:0]        cfg_nsym,
  input  logic signed [DW-1:0] di_re,
  input  logic signed [DW-1:0] di_im,
  input  logic                 di_vld,
  output logic signed [DW-1:0] do_re,
  output logic signed [DW-1:0] do_im,
  output logic                 do_vld,
  output logic                 do_sop,
  output logic                 do_eop,
  output logic [SW-1:0]        do_sym,
  output logic                 err_short
);

  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_SOP = KW'(GF);
  localparam logic [KW-1:0] K_EOP = KW'(N - GB - 1);

  logic [KW-1:0] beat_k;
  logic [SW-1:0] beat_s;
  logic [SW-1:0] beat_nsym;
  logic          trunc;
  logic          payload;

  sym_sample_cnt #(
    .N  (N),
    .SW (SW),
    .KW (KW)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .frm_start (frm_start),
    .di_vld    (di_vld),
    .cfg_nsym  (cfg_nsym),
    .beat_k    (beat_k),
    .beat_s    (beat_s),
    .beat_nsym (beat_nsym),
    .trunc     (trunc)
  );

  assign payload = di_vld && (beat_k >= K_SOP) && (beat_k <= K_EOP) &&
                   (beat_s < beat_nsym);

  // NOTE: the sample registers are reset along with the flags so every output
  // reads 0 during and right after reset; they are plain flops, not memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_re     <= '0;
      do_im     <= '0;
      do_vld    <= 1'b0;
      do_sop    <= 1'b0;
      do_eop    <= 1'b0;
      do_sym    <= '0;
      err_short <= 1'b0;
    end else begin
      do_re     <= di_re;
      do_im     <= di_im;
      do_vld    <= payload;
      do_sop    <= payload && (beat_k == K_SOP);
      do_eop    <= payload && (beat_k == K_EOP);
      do_sym    <= beat_s;
      err_short <= trunc;
    end
  end

endmodule

// File: tb/tb_payload_window_sel.sv
// tb_payload_window_sel -- scoreboard bench for payload_window_sel. Two
// instances share stimulus: dut0 with default parameters, dut1 with N=64,
// GF=4, GB=8, SW=2.
module tb_payload_window_sel;

  typedef struct packed {
    logic       vld;
    logic       sop;
    logic       eop;
    logic       err;
    logic [3:0] sym;
    logic [13:0] re;
    logic [13:0] im;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frm_start = 1'b0;
  logic [3:0]  cfg_nsym = '0;
  logic [1:0]  cfg_nsym1;
  logic signed [13:0] di_re = '0, di_im = '0;
  logic        di_vld = 1'b0;

  logic signed [13:0] do_re0, do_im0, do_re1, do_im1;
  logic        do_vld0, do_sop0, do_eop0, err0;
  logic        do_vld1, do_sop1, do_eop1, err1;
  logic [3:0]  do_sym0;
  logic [1:0]  do_sym1;

  assign cfg_nsym1 = cfg_nsym[1:0];

  always #5 clk = ~clk;

  payload_window_sel dut0 (
    .clk(clk), .rst_n(rst_n), .frm_start(frm_start), .cfg_nsym(cfg_nsym),
    .di_re(di_re), .di_im(di_im), .di_vld(di_vld),
    .do_re(do_re0), .do_im(do_im0), .do_vld(do_vld0), .do_sop(do_sop0),
    .do_eop(do_eop0), .do_sym(do_sym0), .err_short(err0)
  );

  payload_window_sel #(.DW(14), .N(64), .GF(4), .GB(8), .SW(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .frm_start(frm_start), .cfg_nsym(cfg_nsym1),
    .di_re(di_re), .di_im(di_im), .di_vld(di_vld),
    .do_re(do_re1), .do_im(do_im1), .do_vld(do_vld1), .do_sop(do_sop1),
    .do_eop(do_eop1), .do_sym(do_sym1), .err_short(err1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state per instance
  int mk[2], ms[2], mn[2];

  exp_t sb0[$], sb1[$];
  int   beatq[$];
  int   beat;

  // statistics taken from the DUT outputs, compared against constants
  int vld_cnt0, sop_cnt0, eop_cnt0, err_cnt0, sop_pos_bad, eop_pos_bad;
  int vld_cnt1, err_cnt1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    beat = 0;
    vld_cnt0 = 0; sop_cnt0 = 0; eop_cnt0 = 0; err_cnt0 = 0;
    sop_pos_bad = 0; eop_pos_bad = 0;
    vld_cnt1 = 0; err_cnt1 = 0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mk[d] = 0; ms[d] = 0; mn[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic v, input logic fs,
                            input logic [3:0] ns, input logic [13:0] re,
                            input logic [13:0] im, output exp_t e);
    int n, gf, gb, ke, se, ne;
    n  = (d == 0) ? 512 : 64;
    gf = (d == 0) ? 16 : 4;
    gb = (d == 0) ? 16 : 8;
    ke = fs ? 0 : mk[d];
    se = fs ? 0 : ms[d];
    ne = fs ? ((d == 0) ? int'(ns) : int'(ns[1:0])) : mn[d];
    e.vld = v && (ke >= gf) && (ke <= n - gb - 1) && (se < ne);
    e.sop = e.vld && (ke == gf);
    e.eop = e.vld && (ke == n - gb - 1);
    e.err = !v && !fs && (mk[d] != 0);
    e.sym = 4'(se);
    e.re  = re;
    e.im  = im;
    mn[d] = ne;
    if (v) begin
      if (ke == n - 1) begin
        mk[d] = 0;
        ms[d] = (se < ne) ? se + 1 : se;
      end else begin
        mk[d] = ke + 1;
        ms[d] = se;
      end
    end else begin
      mk[d] = 0;
      ms[d] = se;
    end
  endtask

  // Drive one beat, predict both outputs, then compare one cycle later.
  task automatic step(input logic v, input logic fs, input logic [3:0] ns);
    exp_t e0, e1, x0, x1;
    logic [13:0] re, im;
    int b;
    re = 14'($urandom);
    im = 14'($urandom);
    di_vld = v; frm_start = fs; cfg_nsym = ns; di_re = re; di_im = im;
    model_step(0, v, fs, ns, re, im, e0);
    model_step(1, v, fs, ns, re, im, e1);
    sb0.push_back(e0);
    sb1.push_back(e1);
    beatq.push_back(v ? beat : -1);
    if (v) beat++;
    @(posedge clk);
    #1;
    if (sb0.size() == 0 || sb1.size() == 0 || beatq.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_underflow: got empty queue, expected entry");
    end else begin
      x0 = sb0.pop_front();
      x1 = sb1.pop_front();
      b  = beatq.pop_front();
      check("sb_dut0", 64'({do_vld0, do_sop0, do_eop0, err0, do_sym0, do_re0, do_im0}), 64'(x0));
      check("sb_dut1", 64'({do_vld1, do_sop1, do_eop1, err1, 2'b00, do_sym1, do_re1, do_im1}), 64'(x1));
      if (do_vld0) vld_cnt0++;
      if (do_sop0) begin
        sop_cnt0++;
        if (b < 16 || (b - 16) % 512 != 0) sop_pos_bad++;
      end
      if (do_eop0) begin
        eop_cnt0++;
        if (b < 495 || (b - 495) % 512 != 0) eop_pos_bad++;
      end
      if (err0) err_cnt0++;
      if (do_vld1) vld_cnt1++;
      if (err1) err_cnt1++;
    end
    frm_start = 1'b0;
  endtask

  task automatic run(input int beats);
    for (int i = 0; i < beats; i++) step(1'b1, 1'b0, cfg_nsym);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, cfg_nsym);
  endtask

  initial begin
    model_reset();
    clear_stats();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state_dut0", 64'({do_vld0, do_sop0, do_eop0, err0, do_sym0, do_re0, do_im0}), 64'd0);
    check("rst_state_dut1", 64'({do_vld1, do_sop1, do_eop1, err1, do_sym1, do_re1, do_im1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // continuous frame: 6 symbols, 5 payload
    step(1'b0, 1'b1, 4'd5);
    clear_stats();
    run(6 * 512);
    check("cont_vld_cnt", 64'(vld_cnt0), 64'(5 * 480));
    check("cont_sop_cnt", 64'(sop_cnt0), 64'd5);
    check("cont_eop_cnt", 64'(eop_cnt0), 64'd5);
    check("cont_sop_pos", 64'(sop_pos_bad), 64'd0);
    check("cont_eop_pos", 64'(eop_pos_bad), 64'd0);
    check("cont_last_sym", 64'(do_sym0), 64'd5);
    check("cont_no_err", 64'(err_cnt0), 64'd0);

    // idle gaps of 1 and 7 cycles on symbol boundaries
    step(1'b0, 1'b1, 4'd5);
    clear_stats();
    run(512); idle(1);
    run(512); idle(7);
    run(4 * 512);
    check("gap_vld_cnt", 64'(vld_cnt0), 64'(5 * 480));
    check("gap_sop_pos", 64'(sop_pos_bad), 64'd0);
    check("gap_no_err0", 64'(err_cnt0), 64'd0);
    check("gap_no_err1", 64'(err_cnt1), 64'd0);

    // truncation after 300 beats of symbol 1
    step(1'b0, 1'b1, 4'd5);
    clear_stats();
    run(512 + 300);
    idle(1);
    check("trunc_err_pulse", 64'(err0), 64'd1);
    run(17);
    check("trunc_restart_sop_sym", 64'({do_sop0, do_sym0}), 64'({1'b1, 4'd1}));
    run(512 - 17);
    check("trunc_err_once", 64'(err_cnt0), 64'd1);

    // frm_start coincident with a valid beat at k=200 of symbol 2
    step(1'b0, 1'b1, 4'd5);
    run(2 * 512 + 200);
    clear_stats();
    step(1'b1, 1'b1, 4'd1);
    check("coinc_beat", 64'({do_vld0, do_sym0, err0}), 64'd0);
    run(16);
    check("coinc_sop_sym0", 64'({do_sop0, do_sym0}), 64'({1'b1, 4'd0}));
    run(2 * 512 - 17);
    check("coinc_vld_cnt", 64'(vld_cnt0), 64'd480);
    check("coinc_no_err", 64'(err_cnt0), 64'd0);

    // asynchronous reset mid-symbol
    step(1'b0, 1'b1, 4'd5);
    run(250);
    check("pre_rst_vld", 64'(do_vld0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dut0", 64'({do_vld0, do_sop0, do_eop0, err0, do_sym0, do_re0, do_im0}), 64'd0);
    check("async_rst_dut1", 64'({do_vld1, do_sop1, do_eop1, err1, do_sym1, do_re1, do_im1}), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    run(600);
    check("post_rst_no_vld0", 64'(vld_cnt0), 64'd0);
    check("post_rst_no_vld1", 64'(vld_cnt1), 64'd0);
    check("post_rst_no_err", 64'(err_cnt0), 64'd0);

    // small instance: 3 payload symbols of 52 samples, s saturates at 3
    step(1'b0, 1'b1, 4'd3);
    clear_stats();
    run(6 * 64);
    check("small_vld_cnt", 64'(vld_cnt1), 64'(3 * 52));
    check("small_sym_sat", 64'(do_sym1), 64'd3);
    check("small_no_err", 64'(err_cnt1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
